// File: rtl/dual_issue_dispatch.sv
// Dual-issue dispatch: in-order queue, RST renaming, one issue per RS per cycle; `CDB_BYPASS_EN zeroes tags on the CDB.
// Latency: enqueued at edge N, issue strobes valid in the following cycle, popped at edge N+1 unless stalled.
// Backpressure: in_ready drops below two free entries; AR_Status/MR_Status stall the head strictly in order.
module dual_issue_dispatch #(
    parameter int DEPTH    = 8,
    parameter int NUM_REGS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_inst1_type,
    input  logic [7:0] in_inst1_dst,
    input  logic [7:0] in_inst1_src1,
    input  logic [7:0] in_inst1_src2,
    input  logic [7:0] in_inst2_type,
    input  logic [7:0] in_inst2_dst,
    input  logic [7:0] in_inst2_src1,
    input  logic [7:0] in_inst2_src2,
    input  logic       AR_Status,
    input  logic       MR_Status,
    input  logic       cdb_valid,
    input  logic [3:0] cdb_tag,
    output logic       add_issue_valid,
    output logic [7:0] add_issue_op,
    output logic [3:0] add_issue_tag,
    output logic [3:0] add_issue_q1,
    output logic [3:0] add_issue_q2,
    output logic [7:0] add_issue_r1,
    output logic [7:0] add_issue_r2,
    output logic       mul_issue_valid,
    output logic [7:0] mul_issue_op,
    output logic [3:0] mul_issue_tag,
    output logic [3:0] mul_issue_q1,
    output logic [3:0] mul_issue_q2,
    output logic [7:0] mul_issue_r1,
    output logic [7:0] mul_issue_r2
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = $clog2(NUM_REGS);

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] dst;
        logic [7:0] src1;
        logic [7:0] src2;
    } inst_t;

    typedef struct packed {
        logic       vld;
        logic [7:0] op;
        logic [3:0] tag;
        logic [3:0] q1;
        logic [3:0] q2;
        logic [7:0] r1;
        logic [7:0] r2;
    } issue_t;

    inst_t         queue [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [3:0]    rst_tab [NUM_REGS];
    logic [2:0]    add_cnt;
    logic [2:0]    mul_cnt;

    function automatic logic legal_op(input logic [7:0] op);
        return (op >= 8'd1) && (op <= 8'd4);
    endfunction

    function automatic logic is_mul(input logic [7:0] op);
        return (op == 8'd3) || (op == 8'd4);
    endfunction

    function automatic logic reg_ok(input logic [7:0] r);
        return int'(r) < NUM_REGS;
    endfunction

    function automatic logic [2:0] cnt_next(input logic [2:0] c);
        return (c == 3'd7) ? 3'd1 : c + 3'd1;
    endfunction

    // RST read before this edge's update; untracked registers always read as ready.
    function automatic logic [3:0] rst_lookup(input logic [7:0] src);
        logic [3:0] q;
        q = 4'd0;
        if (reg_ok(src)) begin
            q = rst_tab[src[RW-1:0]];
`ifdef CDB_BYPASS_EN
            if (cdb_valid && (q == cdb_tag)) begin
                q = 4'd0;
            end
`endif
        end
        return q;
    endfunction

    // ---------------- enqueue ----------------
    inst_t      in1;
    inst_t      in2;
    logic       enq_go;
    logic       leg1;
    logic       leg2;
    logic [1:0] enq_n;

    assign in1      = {in_inst1_type, in_inst1_dst, in_inst1_src1, in_inst1_src2};
    assign in2      = {in_inst2_type, in_inst2_dst, in_inst2_src1, in_inst2_src2};
    assign in_ready = (DEPTH - int'(count)) >= 2;
    assign enq_go   = in_valid && in_ready;
    assign leg1     = enq_go && legal_op(in1.op);
    assign leg2     = enq_go && legal_op(in2.op);
    assign enq_n    = {1'b0, leg1} + {1'b0, leg2};

    always_ff @(posedge clk) begin
        if (leg1) begin
            queue[wr_ptr] <= in1;
        end
        if (leg2) begin
            queue[wr_ptr + PW'(leg1)] <= in2;
        end
    end

    // ---------------- issue selection ----------------
    inst_t      h0;
    inst_t      h1;
    logic       h0_vld;
    logic       h1_vld;
    logic       h0_mul;
    logic       h0_iss;
    logic       h1_iss;
    logic [3:0] h0_tag;
    logic [3:0] h1_tag;
    logic [1:0] pop_n;

    assign h0     = queue[rd_ptr];
    assign h1     = queue[rd_ptr + PW'(1)];
    assign h0_vld = count != '0;
    assign h1_vld = count >= CW'(2);
    assign h0_mul = is_mul(h0.op);
    assign h0_iss = h0_vld && !(h0_mul ? MR_Status : AR_Status);
    // The second slot can only go to the unit the head did not use.
    assign h1_iss = h0_iss && h1_vld && (is_mul(h1.op) != h0_mul)
                    && !(h0_mul ? AR_Status : MR_Status);
    assign h0_tag = {h0_mul, h0_mul ? mul_cnt : add_cnt};
    assign h1_tag = {~h0_mul, h0_mul ? add_cnt : mul_cnt};
    assign pop_n  = {1'b0, h0_iss} + {1'b0, h1_iss};

    function automatic logic [3:0] h1_lookup(input logic [7:0] src);
        if (!reg_ok(src)) begin
            return 4'd0;
        end
        if (src == h0.dst) begin
            return h0_tag;
        end
        return rst_lookup(src);
    endfunction

    issue_t slot0;
    issue_t slot1;
    issue_t add_slot;
    issue_t mul_slot;

    always_comb begin
        slot0 = '0;
        slot1 = '0;
        if (h0_iss) begin
            slot0.vld = 1'b1;
            slot0.op  = h0.op;
            slot0.tag = h0_tag;
            slot0.q1  = rst_lookup(h0.src1);
            slot0.q2  = rst_lookup(h0.src2);
            slot0.r1  = h0.src1;
            slot0.r2  = h0.src2;
        end
        if (h1_iss) begin
            slot1.vld = 1'b1;
            slot1.op  = h1.op;
            slot1.tag = h1_tag;
            slot1.q1  = h1_lookup(h1.src1);
            slot1.q2  = h1_lookup(h1.src2);
            slot1.r1  = h1.src1;
            slot1.r2  = h1.src2;
        end
    end

    always_comb begin
        add_slot = slot0;
        mul_slot = slot1;
        if (h0_mul) begin
            add_slot = slot1;
            mul_slot = slot0;
        end
    end

    assign add_issue_valid = add_slot.vld;
    assign add_issue_op    = add_slot.op;
    assign add_issue_tag   = add_slot.tag;
    assign add_issue_q1    = add_slot.q1;
    assign add_issue_q2    = add_slot.q2;
    assign add_issue_r1    = add_slot.r1;
    assign add_issue_r2    = add_slot.r2;
    assign mul_issue_valid = mul_slot.vld;
    assign mul_issue_op    = mul_slot.op;
    assign mul_issue_tag   = mul_slot.tag;
    assign mul_issue_q1    = mul_slot.q1;
    assign mul_issue_q2    = mul_slot.q2;
    assign mul_issue_r1    = mul_slot.r1;
    assign mul_issue_r2    = mul_slot.r2;

    // ---------------- state update ----------------
    logic add_inc;
    logic mul_inc;

    assign add_inc = (h0_iss && !h0_mul) || (h1_iss && h0_mul);
    assign mul_inc = (h0_iss && h0_mul) || (h1_iss && !h0_mul);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            add_cnt <= 3'd1;
            mul_cnt <= 3'd1;
        end else begin
            rd_ptr <= rd_ptr + PW'(pop_n);
            wr_ptr <= wr_ptr + PW'(enq_n);
            count  <= count + CW'(enq_n) - CW'(pop_n);
            if (add_inc) begin
                add_cnt <= cnt_next(add_cnt);
            end
            if (mul_inc) begin
                mul_cnt <= cnt_next(mul_cnt);
            end
        end
    end

    // Later non-blocking writes override: CDB clear < h0 rename < h1 rename.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rst_tab[i] <= 4'd0;
            end
        end else begin
            if (cdb_valid) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (rst_tab[i] == cdb_tag) begin
                        rst_tab[i] <= 4'd0;
                    end
                end
            end
            if (h0_iss && reg_ok(h0.dst)) begin
                rst_tab[h0.dst[RW-1:0]] <= h0_tag;
            end
            if (h1_iss && reg_ok(h1.dst)) begin
                rst_tab[h1.dst[RW-1:0]] <= h1_tag;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_dispatch.sv
// Bench for dual_issue_dispatch: directed scenarios then random traffic against a queue-based reference model.
module tb_dual_issue_dispatch;
    localparam int DEPTH    = 8;
    localparam int NUM_REGS = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] t1 = '0, d1 = '0, s11 = '0, s12 = '0;
    logic [7:0] t2 = '0, d2 = '0, s21 = '0, s22 = '0;
    logic       ar = 1'b0, mr = 1'b0, cdb_valid = 1'b0;
    logic [3:0] cdb_tag = '0;
    logic       add_v, mul_v;
    logic [7:0] add_op, mul_op, add_r1, add_r2, mul_r1, mul_r2;
    logic [3:0] add_tag, add_q1, add_q2, mul_tag, mul_q1, mul_q2;

    always #5 clk = ~clk;

    dual_issue_dispatch #(.DEPTH(DEPTH), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst1_type(t1), .in_inst1_dst(d1), .in_inst1_src1(s11), .in_inst1_src2(s12),
        .in_inst2_type(t2), .in_inst2_dst(d2), .in_inst2_src1(s21), .in_inst2_src2(s22),
        .AR_Status(ar), .MR_Status(mr), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .add_issue_valid(add_v), .add_issue_op(add_op), .add_issue_tag(add_tag),
        .add_issue_q1(add_q1), .add_issue_q2(add_q2), .add_issue_r1(add_r1), .add_issue_r2(add_r2),
        .mul_issue_valid(mul_v), .mul_issue_op(mul_op), .mul_issue_tag(mul_tag),
        .mul_issue_q1(mul_q1), .mul_issue_q2(mul_q2), .mul_issue_r1(mul_r1), .mul_issue_r2(mul_r2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { int op; int dst; int s1; int s2; } minst_t;
    typedef struct { bit vld; int op; int tag; int q1; int q2; int r1; int r2; } miss_t;

    minst_t mq[$];
    int     rst_m [NUM_REGS];
    int     cnt_add, cnt_mul;

    function automatic minst_t mk(input int op, input int dst, input int s1, input int s2);
        minst_t m;
        m.op = op; m.dst = dst; m.s1 = s1; m.s2 = s2;
        return m;
    endfunction

    function automatic bit m_is_mul(input int op);
        return op == 3 || op == 4;
    endfunction

    function automatic void model_reset();
        mq.delete();
        foreach (rst_m[i]) rst_m[i] = 0;
        cnt_add = 1;
        cnt_mul = 1;
    endfunction

    function automatic int lookup(input int src, input bit cv, input int ct);
        int q;
        if (src >= NUM_REGS) return 0;
        q = rst_m[src];
`ifdef CDB_BYPASS_EN
        if (cv && q == ct) q = 0;
`endif
        return q;
    endfunction

    function automatic logic [35:0] pack_exp(input miss_t e);
        return {8'(e.op), 4'(e.tag), 4'(e.q1), 4'(e.q2), 8'(e.r1), 8'(e.r2)};
    endfunction

    // One clock: drive at negedge, compare just after, then advance the model past the next rising edge.
    task automatic cycle(input bit iv, input minst_t a, input minst_t b,
                         input bit ars, input bit mrs, input bit cv, input int ct);
        miss_t e0, e1, ea, em;
        bit    h0m, rdy;
        @(negedge clk);
        in_valid = iv;
        t1 = 8'(a.op); d1 = 8'(a.dst); s11 = 8'(a.s1); s12 = 8'(a.s2);
        t2 = 8'(b.op); d2 = 8'(b.dst); s21 = 8'(b.s1); s22 = 8'(b.s2);
        ar = ars; mr = mrs; cdb_valid = cv; cdb_tag = 4'(ct);
        #1;
        rdy = (DEPTH - mq.size()) >= 2;
        check("in_ready", 64'(in_ready), 64'(rdy));
        e0 = '{default: 0};
        e1 = '{default: 0};
        h0m = 0;
        if (mq.size() >= 1) begin
            h0m = m_is_mul(mq[0].op);
            if (!(h0m ? mrs : ars)) begin
                e0 = '{1, mq[0].op, h0m ? 8 + cnt_mul : cnt_add,
                       lookup(mq[0].s1, cv, ct), lookup(mq[0].s2, cv, ct), mq[0].s1, mq[0].s2};
            end
        end
        if (e0.vld && mq.size() >= 2 && m_is_mul(mq[1].op) != h0m && !(h0m ? ars : mrs)) begin
            e1.vld = 1; e1.op = mq[1].op; e1.tag = h0m ? cnt_add : 8 + cnt_mul;
            e1.r1 = mq[1].s1; e1.r2 = mq[1].s2;
            e1.q1 = (mq[1].s1 >= NUM_REGS) ? 0 : (mq[1].s1 == mq[0].dst) ? e0.tag : lookup(mq[1].s1, cv, ct);
            e1.q2 = (mq[1].s2 >= NUM_REGS) ? 0 : (mq[1].s2 == mq[0].dst) ? e0.tag : lookup(mq[1].s2, cv, ct);
        end
        ea = h0m ? e1 : e0;
        em = h0m ? e0 : e1;
        check("add_valid", 64'(add_v), 64'(ea.vld));
        check("mul_valid", 64'(mul_v), 64'(em.vld));
        if (ea.vld) check("add_bundle", 64'({add_op, add_tag, add_q1, add_q2, add_r1, add_r2}), 64'(pack_exp(ea)));
        if (em.vld) check("mul_bundle", 64'({mul_op, mul_tag, mul_q1, mul_q2, mul_r1, mul_r2}), 64'(pack_exp(em)));
        // state after the coming edge
        if (cv) foreach (rst_m[i]) if (rst_m[i] == ct) rst_m[i] = 0;
        if (e0.vld) begin
            if (mq[0].dst < NUM_REGS) rst_m[mq[0].dst] = e0.tag;
            if (h0m) cnt_mul = cnt_mul % 7 + 1; else cnt_add = cnt_add % 7 + 1;
        end
        if (e1.vld) begin
            if (mq[1].dst < NUM_REGS) rst_m[mq[1].dst] = e1.tag;
            if (h0m) cnt_add = cnt_add % 7 + 1; else cnt_mul = cnt_mul % 7 + 1;
        end
        if (e1.vld) void'(mq.pop_front());
        if (e0.vld) void'(mq.pop_front());
        if (iv && rdy) begin
            if (a.op >= 1 && a.op <= 4) mq.push_back(a);
            if (b.op >= 1 && b.op <= 4) mq.push_back(b);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_valids", 64'({add_v, mul_v}), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(1));
        check("rst_outs", 64'({add_op, add_tag, add_q1, add_q2, mul_op, mul_tag, mul_q1, mul_q2}), 64'(0));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    minst_t nop, ra, rb;

    initial begin
        nop = mk(0, 0, 0, 0);
        #3;
        do_reset();

        // ADD + MUL pair: both issue together with fresh tags
        cycle(1, mk(1, 1, 2, 3), mk(3, 4, 5, 6), 0, 0, 0, 0);
        cycle(0, nop, nop, 0, 0, 0, 0);
        check("t1_add_tag", 64'(add_tag), 64'(1));
        check("t1_mul_tag", 64'(mul_tag), 64'(9));
        check("t1_qs", 64'({add_q1, add_q2, mul_q1, mul_q2}), 64'(0));
        cycle(0, nop, nop, 0, 0, 0, 0);
        check("t1_popped", 64'({add_v, mul_v}), 64'(0));

        // same-unit pair: second waits, sees first's tag on both sources
        do_reset();
        cycle(1, mk(1, 1, 2, 3), mk(2, 5, 1, 1), 0, 0, 0, 0);
        cycle(0, nop, nop, 0, 0, 0, 0);
        check("t2_first", 64'({add_v, mul_v, add_tag}), 64'({2'b10, 4'd1}));
        cycle(0, nop, nop, 0, 0, 0, 0);
        check("t2_second", 64'({add_tag, add_q1, add_q2}), 64'({4'd2, 4'd1, 4'd1}));

        // stalled head blocks the younger MUL
        do_reset();
        cycle(1, mk(1, 1, 2, 3), mk(3, 4, 5, 6), 1, 0, 0, 0);
        cycle(0, nop, nop, 1, 0, 0, 0);
        check("t3_stall", 64'({add_v, mul_v}), 64'(0));
        cycle(0, nop, nop, 0, 0, 0, 0);
        check("t3_go", 64'({add_v, mul_v}), 64'(2'b11));

        // CDB clear vs concurrent rename
        do_reset();
        cycle(1, mk(3, 1, 2, 3), nop, 0, 0, 0, 0);
        cycle(0, nop, nop, 0, 0, 0, 0);
        cycle(1, mk(1, 7, 1, 0), mk(3, 1, 2, 3), 0, 0, 0, 0);
        cycle(0, nop, nop, 0, 0, 1, 9);
`ifdef CDB_BYPASS_EN
        check("t4_src_q", 64'(add_q1), 64'(0));
`else
        check("t4_src_q", 64'(add_q1), 64'(9));
`endif
        check("t4_mul_tag", 64'(mul_tag), 64'(10));
        cycle(1, mk(1, 8, 1, 1), nop, 0, 0, 0, 0);
        cycle(0, nop, nop, 0, 0, 0, 0);
        check("t4_issue_wins", 64'(add_q1), 64'(10));
        cycle(0, nop, nop, 0, 0, 1, 10);
        cycle(1, mk(1, 9, 1, 0), nop, 0, 0, 0, 0);
        cycle(0, nop, nop, 0, 0, 0, 0);
        check("t4_cleared", 64'(add_q1), 64'(0));

        // fill to full, then drain MULs across the counter wrap
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, mk(3, i, 1, 2), mk(4, i + 4, 3, 4), 1, 1, 0, 0);
            if (i == 2) begin
                cycle(0, nop, nop, 1, 1, 0, 0);
                check("t5_ready_6", 64'(in_ready), 64'(1));
            end
        end
        cycle(1, mk(3, 9, 9, 9), mk(3, 9, 9, 9), 1, 1, 0, 0);
        check("t5_full", 64'(in_ready), 64'(0));
        for (int i = 0; i < 8; i++) begin
            cycle(0, nop, nop, 1, 0, 0, 0);
            check("t5_tag", 64'({mul_v, mul_tag}), 64'({1'b1, 4'(8 + i % 7 + 1)}));
        end
        cycle(0, nop, nop, 1, 0, 0, 0);
        check("t5_empty", 64'({mul_v, in_ready}), 64'(2'b01));

        // async reset with five entries queued and both strobes high
        do_reset();
        cycle(1, mk(1, 1, 2, 3), mk(3, 4, 5, 6), 1, 1, 0, 0);
        cycle(1, mk(2, 2, 1, 4), mk(4, 3, 1, 4), 1, 1, 0, 0);
        cycle(1, mk(1, 5, 2, 3), nop, 1, 1, 0, 0);
        cycle(0, nop, nop, 0, 0, 0, 0);
        check("t6_pre", 64'({add_v, mul_v}), 64'(2'b11));
        do_reset();
        cycle(1, mk(1, 6, 1, 4), mk(3, 7, 2, 3), 0, 0, 0, 0);
        cycle(0, nop, nop, 0, 0, 0, 0);
        check("t6_after", 64'({add_tag, mul_tag, add_q1, add_q2, mul_q1, mul_q2}), 64'({4'd1, 4'd9, 16'd0}));

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            minst_t x[2];
            int     ct;
            if (n == 1500) do_reset();
            for (int k = 0; k < 2; k++) begin
                x[k].op  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 5);
                x[k].dst = ($urandom_range(0, 15) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 7);
                x[k].s1  = ($urandom_range(0, 15) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 7);
                x[k].s2  = ($urandom_range(0, 15) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 7);
            end
            ct = ($urandom_range(0, 1) == 0) ? rst_m[$urandom_range(0, NUM_REGS - 1)] : $urandom_range(0, 15);
            ra = x[0];
            rb = x[1];
            cycle($urandom_range(0, 2) != 0, ra, rb,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, ct);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
